// File: rtl/serial_add4_accum.sv
// serial_add4_accum
//   Bit-serial adder for four unsigned operands. Each cycle it adds one bit
//   column from every operand plus a 2-bit running carry, which is the job of
//   a 4-input full-adder cell. It emits one sum bit per cycle, LSB first.
//   Two flush cycles drain the carry into the top two result bits. The full
//   (WIDTH+2)-bit total is then held on `result` until the next accepted start.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset (aborts any operation)
//   start      request a new addition; only looked at while ready=1
//   op_a..op_d WIDTH-bit operands, captured on the accepting edge only
//   ready      1 while idle (start will be accepted)
//   busy       inverse of ready (shifting or signalling done)
//   sum_bit    registered serial sum bit, LSB first
//   sum_valid  1 for each cycle that sum_bit carries a new bit
//   result     op_a+op_b+op_c+op_d, final when done=1
//   done       one-cycle pulse when result is complete
module serial_add4_accum #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] op_c,
  input  logic [WIDTH-1:0] op_d,
  output logic             ready,
  output logic             busy,
  output logic             sum_bit,
  output logic             sum_valid,
  output logic [WIDTH+1:0] result,
  output logic             done
);

  // Counter must hold WIDTH+1 (the last flush position) without wrapping.
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic [WIDTH-1:0] r_d;
  logic [1:0]       r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sum_bit;
  logic             r_sum_valid;
  logic             r_done;
  logic [WIDTH+1:0] r_result;

  logic [2:0]       w_total;
  logic [WIDTH+1:0] w_bit_sel;
  logic [WIDTH+1:0] w_result_next;

  // Column sum: four data bits plus a carry of at most 3 gives at most 7.
  // The carry out t[2:1] is therefore also at most 3.
  assign w_total = 3'(r_a[0]) + 3'(r_b[0]) + 3'(r_c[0]) + 3'(r_d[0]) + 3'(r_carry);

  // One-hot select of the result bit written by the current bit position.
  for (genvar gi = 0; gi < WIDTH + 2; gi++) begin : g_bit_sel
    assign w_bit_sel[gi] = (r_cnt == CNT_W'(gi));
  end

  assign w_result_next = (r_result & ~w_bit_sel) | (w_bit_sel & {(WIDTH+2){w_total[0]}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_d         <= '0;
      r_carry     <= '0;
      r_cnt       <= '0;
      r_sum_bit   <= 1'b0;
      r_sum_valid <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= op_a;
            r_b      <= op_b;
            r_c      <= op_c;
            r_d      <= op_d;
            r_carry  <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_sum_bit   <= w_total[0];
          r_carry     <= w_total[2:1];
          r_result    <= w_result_next;
          r_sum_valid <= 1'b1;
          // Zero fill supplies the flush-cycle operand bits.
          r_a         <= r_a >> 1;
          r_b         <= r_b >> 1;
          r_c         <= r_c >> 1;
          r_d         <= r_d >> 1;
          if (r_cnt == LAST_CNT) begin
            // Counter is left at its final value so it never wraps.
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_done      <= 1'b0;
          r_sum_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready     = (r_state == S_IDLE);
  assign busy      = ~ready;
  assign sum_bit   = r_sum_bit;
  assign sum_valid = r_sum_valid;
  assign done      = r_done;
  assign result    = r_result;

endmodule

// File: tb/tb_serial_add4_accum.sv
module tb_serial_add4_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       s8_start;
  logic [7:0] a8, b8, c8, d8;
  logic       ready8, busy8, sum_bit8, sum_valid8, done8;
  logic [9:0] result8;

  logic       s2_start;
  logic [1:0] a2, b2, c2, d2;
  logic       ready2, busy2, sum_bit2, sum_valid2, done2;
  logic [3:0] result2;

  serial_add4_accum #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8_start),
    .op_a(a8), .op_b(b8), .op_c(c8), .op_d(d8),
    .ready(ready8), .busy(busy8), .sum_bit(sum_bit8), .sum_valid(sum_valid8),
    .result(result8), .done(done8)
  );

  serial_add4_accum #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(s2_start),
    .op_a(a2), .op_b(b2), .op_c(c2), .op_d(d2),
    .ready(ready2), .busy(busy2), .sum_bit(sum_bit2), .sum_valid(sum_valid2),
    .result(result2), .done(done2)
  );

  int checks = 0;
  int errors = 0;
  int sel = 0;
  logic chk_en = 1'b0;

  // Outputs of whichever instance the transaction task is driving.
  logic       c_ready, c_sv, c_sb, c_done;
  logic [9:0] c_result;
  assign c_ready  = (sel == 1) ? ready2     : ready8;
  assign c_sv     = (sel == 1) ? sum_valid2 : sum_valid8;
  assign c_sb     = (sel == 1) ? sum_bit2   : sum_bit8;
  assign c_done   = (sel == 1) ? done2      : done8;
  assign c_result = (sel == 1) ? {6'b0, result2} : result8;

  // Behavioural model: an accepted operation is "age p" edges old.
  // At age p, bits 0..p-1 of the total are out; done shows at age W+2.
  int          m_act[2]  = '{0, 0};
  int          m_p[2]    = '{0, 0};
  logic [31:0] m_s[2]    = '{32'd0, 32'd0};
  logic [31:0] m_last[2] = '{32'd0, 32'd0};

  function automatic int wid(input int idx);
    return (idx == 1) ? 2 : 8;
  endfunction

  task automatic mstep(input int idx, input logic st, input int sum);
    int w;
    w = wid(idx);
    if (rst) begin
      m_act[idx]  = 0;
      m_last[idx] = 32'd0;
    end else if (m_act[idx] == 0) begin
      if (st) begin
        m_act[idx] = 1;
        m_p[idx]   = 0;
        m_s[idx]   = 32'(sum);
      end
    end else if (m_p[idx] == w + 2) begin
      m_act[idx]  = 0;
      m_last[idx] = m_s[idx];
    end else begin
      m_p[idx] = m_p[idx] + 1;
    end
  endtask

  // Packed {ready, busy, sum_valid, done, sum_bit, result[9:0]}.
  function automatic logic [14:0] mexp(input int idx);
    int p, w;
    logic sv, dn, sb;
    logic [31:0] mask;
    w = wid(idx);
    if (m_act[idx] == 0)
      return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, m_last[idx][9:0]};
    p    = m_p[idx];
    sv   = (p >= 1);
    dn   = (p == w + 2);
    sb   = sv ? m_s[idx][p-1] : 1'b0;
    mask = (32'd1 << p) - 32'd1;
    return {1'b0, 1'b1, sv, dn, sb, 10'(m_s[idx] & mask)};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic drive_ops(input int idx, input int a, input int b, input int c, input int d);
    if (idx == 1) begin
      a2 = 2'(a); b2 = 2'(b); c2 = 2'(c); d2 = 2'(d);
    end else begin
      a8 = 8'(a); b8 = 8'(b); c8 = 8'(c); d8 = 8'(d);
    end
  endtask

  // One full transaction on instance idx; returns what was observed.
  task automatic run_op(input int idx, input int a, input int b, input int c, input int d,
                        output logic [9:0] res, output logic [9:0] bits,
                        output int nbits, output int lat);
    int g;
    sel = idx;
    res = '0; bits = '0; nbits = 0; lat = 0;
    @(posedge clk); #1;
    g = 0;
    while (!c_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 50) begin
      chk("ready_timeout", 64'(g), 64'd0);
      return;
    end
    drive_ops(idx, a, b, c, d);
    if (idx == 1) s2_start = 1'b1; else s8_start = 1'b1;
    @(posedge clk); #1;                       // accepting edge E0
    s8_start = 1'b0;
    s2_start = 1'b0;
    drive_ops(idx, int'($urandom), int'($urandom), int'($urandom), int'($urandom));
    while (lat < 40) begin
      @(negedge clk);
      if (c_sv) begin
        if (nbits < 10) bits[nbits] = c_sb;
        nbits++;
      end
      if (c_done) begin
        res = c_result;
        break;
      end
      lat++;
    end
    if (lat >= 40) chk("done_timeout", 64'(lat), 64'd0);
    $display("op w=%0d %0d+%0d+%0d+%0d -> result=%0d bits=%0d latency=%0d",
             wid(idx), a, b, c, d, res, nbits, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] res, bits;
    int nbits, lat, ndn, run, nruns, sum;
    int runs[4];

    rst = 1'b1;
    s8_start = 1'b0; s2_start = 1'b0;
    a8 = '0; b8 = '0; c8 = '0; d8 = '0;
    a2 = '0; b2 = '0; c2 = '0; d2 = '0;

    // Per-cycle compare of both instances against the model.
    fork
      forever begin
        logic [14:0] e, act;
        @(posedge clk);
        mstep(0, s8_start, int'(a8) + int'(b8) + int'(c8) + int'(d8));
        mstep(1, s2_start, int'(a2) + int'(b2) + int'(c2) + int'(d2));
        @(negedge clk);
        if (chk_en) begin
          e   = mexp(0);
          act = {ready8, busy8, sum_valid8, done8, sum_bit8 & e[12], result8};
          chk("cycle_w8", 64'(act), 64'(e));
          e   = mexp(1);
          act = {ready2, busy2, sum_valid2, done2, sum_bit2 & e[12], 6'b0, result2};
          chk("cycle_w2", 64'(act), 64'(e));
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_state", 64'({ready8, busy8, sum_valid8, done8, sum_bit8, result8}),
        64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000}));

    // All zeros.
    run_op(0, 0, 0, 0, 0, res, bits, nbits, lat);
    chk("t1_result", 64'(res), 64'h000);
    chk("t1_bits", 64'(bits), 64'h000);
    chk("t1_nbits", 64'(nbits), 64'd10);
    ndn = 0;
    repeat (4) begin
      @(negedge clk);
      if (done8) ndn++;
    end
    chk("t1_single_done", 64'(ndn), 64'd0);

    // All ones: stream 0,0,1,1,1,1,1,1,1,1.
    run_op(0, 255, 255, 255, 255, res, bits, nbits, lat);
    chk("t2_result", 64'(res), 64'h3FC);
    chk("t2_stream", 64'(bits), 64'b11_1111_1100);

    run_op(0, 1, 1, 1, 1, res, bits, nbits, lat);
    chk("t3a_result", 64'(res), 64'd4);
    chk("t3a_latency", 64'(lat), 64'd10);
    run_op(0, 255, 1, 0, 0, res, bits, nbits, lat);
    chk("t3b_result", 64'(res), 64'd256);
    chk("t3b_stream", 64'(bits), 64'd256);
    chk("t3b_latency", 64'(lat), 64'd10);

    // Start held high for 30 cycles; operands scrambled whenever busy.
    sel = 0;
    @(posedge clk); #1;
    drive_ops(0, 3, 5, 7, 9);
    s8_start = 1'b1;
    ndn = 0; run = 0; nruns = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (ready8) drive_ops(0, 3, 5, 7, 9);
      else drive_ops(0, int'($urandom), int'($urandom), int'($urandom), int'($urandom));
      @(negedge clk);
      if (done8) begin
        ndn++;
        chk("t4_result", 64'(result8), 64'd24);
      end
      if (!ready8) run++;
      else begin
        if (run > 0) begin
          if (nruns < 4) runs[nruns] = run;
          nruns++;
        end
        run = 0;
      end
    end
    s8_start = 1'b0;
    $display("op w=8 held start: done pulses=%0d ready gaps=%0d", ndn, nruns);
    chk("t4_ops", 64'(ndn), 64'd2);
    chk("t4_gaps", 64'(nruns), 64'd2);
    if (nruns >= 2) begin
      chk("t4_gap0", 64'(runs[0]), 64'd11);
      chk("t4_gap1", 64'(runs[1]), 64'd11);
    end
    repeat (16) @(posedge clk);

    // Reset during the fourth shift cycle.
    @(posedge clk); #1;
    drive_ops(0, 200, 100, 50, 25);
    s8_start = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_ready", 64'(ready8), 64'd1);
    chk("t5_result", 64'(result8), 64'd0);
    ndn = 0;
    repeat (15) begin
      if (done8) ndn++;
      @(negedge clk);
    end
    chk("t5_no_done", 64'(ndn), 64'd0);
    $display("op w=8 200+100+50+25 aborted by reset");
    run_op(0, 200, 100, 50, 25, res, bits, nbits, lat);
    chk("t5_fresh", 64'(res), 64'd375);

    // Exhaustive 2-bit operands.
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 4; c++)
          for (int d = 0; d < 4; d++) begin
            sum = a + b + c + d;
            run_op(1, a, b, c, d, res, bits, nbits, lat);
            chk("t6_result", 64'(res), 64'(sum));
            chk("t6_bits", 64'(bits), 64'(sum));
            chk("t6_nbits", 64'(nbits), 64'd4);
          end

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
